// File: rtl/pc_seq.sv
// Program counter for the sequencer: wrapping increment, absolute load, signed
// relative branch and call/return through a small internal return-address stack.
module pc_seq #(
   parameter int WIDTH      = 8,
   parameter int LAST_ADDR  = 24,
   parameter int DEPTH      = 4,
   parameter int RESET_ADDR = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         l,
   input  logic [WIDTH-1:0]             dataIM,
   input  logic                         br,
   input  logic [WIDTH-1:0]             off,
   input  logic                         call,
   input  logic                         ret,
   input  logic                         clr_err,
   output logic [WIDTH-1:0]             pcc,
   output logic [$clog2(DEPTH+1)-1:0]   sp,
   output logic                         ovf,
   output logic                         unf,
   output logic                         aerr
);

   localparam int SPW = $clog2(DEPTH + 1);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [WIDTH-1:0] LAST   = WIDTH'(LAST_ADDR);
   localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_ADDR);
   localparam logic [SPW-1:0]   FULL   = SPW'(DEPTH);

   logic [WIDTH-1:0] pcc_q, pcc_d;
   logic [WIDTH-1:0] inc_addr, top_addr, load_pc;
   logic             load_bad;
   logic [WIDTH:0]   br_target;
   logic [SPW-1:0]   sp_q, sp_d, sp_m1;
   logic             push, set_ovf, set_unf, set_aerr;
   logic             ovf_q, unf_q, aerr_q;
   logic [WIDTH-1:0] stack_q [DEPTH];

   // Increment result doubles as the return address pushed by a call.
   assign inc_addr = (pcc_q == LAST) ? '0 : pcc_q + WIDTH'(1);

   // One extra bit: any true sum outside 0..2**WIDTH-1 lands above LAST here.
   assign br_target = {1'b0, pcc_q} + {off[WIDTH-1], off};

   assign load_bad = (dataIM > LAST);
   assign load_pc  = load_bad ? '0 : dataIM;

   assign sp_m1    = sp_q - SPW'(1);
   assign top_addr = stack_q[sp_m1[IW-1:0]];

   always_comb begin
      pcc_d    = pcc_q;
      sp_d     = sp_q;
      push     = 1'b0;
      set_ovf  = 1'b0;
      set_unf  = 1'b0;
      set_aerr = 1'b0;
      if (en) begin
         if (ret) begin
            if (sp_q != '0) begin
               pcc_d = top_addr;
               sp_d  = sp_m1;
            end else begin
               set_unf = 1'b1;
            end
         end else if (call) begin
            if (sp_q < FULL) begin
               push     = 1'b1;
               sp_d     = sp_q + SPW'(1);
               pcc_d    = load_pc;
               set_aerr = load_bad;
            end else begin
               set_ovf = 1'b1;
            end
         end else if (l) begin
            pcc_d    = load_pc;
            set_aerr = load_bad;
         end else if (br) begin
            if (br_target <= {1'b0, LAST}) begin
               pcc_d = br_target[WIDTH-1:0];
            end else begin
               pcc_d    = '0;
               set_aerr = 1'b1;
            end
         end else begin
            pcc_d = inc_addr;
         end
      end
   end

   // A setting event in the same cycle as clr_err leaves the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcc_q  <= RST_PC;
         sp_q   <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         aerr_q <= 1'b0;
      end else begin
         pcc_q  <= pcc_d;
         sp_q   <= sp_d;
         ovf_q  <= set_ovf  | (ovf_q  & ~clr_err);
         unf_q  <= set_unf  | (unf_q  & ~clr_err);
         aerr_q <= set_aerr | (aerr_q & ~clr_err);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         stack_q[sp_q[IW-1:0]] <= inc_addr;
      end
   end

   assign pcc  = pcc_q;
   assign sp   = sp_q;
   assign ovf  = ovf_q;
   assign unf  = unf_q;
   assign aerr = aerr_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: default instance plus a WIDTH=12 / DEPTH=1 instance.
module tb_pc_seq;

   logic       clk;
   logic       rst_n;
   logic       en, l, br, call, ret, clr_err;
   logic [7:0] dataIM, off;
   logic [7:0] pcc;
   logic [2:0] sp;
   logic       ovf, unf, aerr;

   logic        b_en, b_l, b_br, b_call, b_ret, b_clr_err;
   logic [11:0] b_dataIM, b_off;
   logic [11:0] b_pcc;
   logic        b_sp;
   logic        b_ovf, b_unf, b_aerr;

   int n_vec;
   int n_err;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;

   pc_seq u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .l(l), .dataIM(dataIM), .br(br), .off(off),
      .call(call), .ret(ret), .clr_err(clr_err), .pcc(pcc), .sp(sp),
      .ovf(ovf), .unf(unf), .aerr(aerr)
   );

   pc_seq #(.WIDTH(12), .LAST_ADDR(4095), .DEPTH(1), .RESET_ADDR(100)) u_dut12 (
      .clk(clk), .rst_n(rst_n), .en(b_en), .l(b_l), .dataIM(b_dataIM), .br(b_br),
      .off(b_off), .call(b_call), .ret(b_ret), .clr_err(b_clr_err), .pcc(b_pcc),
      .sp(b_sp), .ovf(b_ovf), .unf(b_unf), .aerr(b_aerr)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] a);
      l = 1'b1; dataIM = a;
      step();
      l = 1'b0;
   endtask

   task automatic do_br(input logic [7:0] o);
      br = 1'b1; off = o;
      step();
      br = 1'b0;
   endtask

   task automatic do_call(input logic [7:0] a);
      call = 1'b1; dataIM = a;
      step();
      call = 1'b0;
   endtask

   task automatic do_ret();
      ret = 1'b1;
      step();
      ret = 1'b0;
   endtask

   task automatic do_clr();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      en = 1'b0; l = 1'b0; br = 1'b0; call = 1'b0; ret = 1'b0; clr_err = 1'b0;
      dataIM = '0; off = '0;
      b_en = 1'b0; b_l = 1'b0; b_br = 1'b0; b_call = 1'b0; b_ret = 1'b0;
      b_clr_err = 1'b0; b_dataIM = '0; b_off = '0;
      step();
      step();
      check("rst_pcc", pcc, 0);
      check("rst_sp", sp, 0);
      check("rst_flags", {ovf, unf, aerr}, 0);

      // reset release and free-running wrap at 24
      rst_n = 1'b1;
      en    = 1'b1;
      exp_q.push_back(8'd0);
      for (int i = 1; i <= 24; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd1);
      check("wrap_pcc", pcc, exp_q.pop_front());
      while (exp_q.size() > 0) begin
         step();
         check("wrap_pcc", pcc, exp_q.pop_front());
      end
      step();
      step();
      check("pre_async_pcc", pcc, 3);
      rst_n = 1'b0;
      #1;
      check("async_rst_pcc", pcc, 0);
      #1;
      rst_n = 1'b1;

      // load, priority, stall
      do_load(8'd5);
      check("ld_5", pcc, 5);
      do_load(8'd20);
      check("ld_20", pcc, 20);
      do_load(8'd24);
      check("ld_last", pcc, 24);
      do_load(8'd10);
      check("ld_beats_wrap", pcc, 10);
      do_load(8'd7);
      l = 1'b1; br = 1'b1; off = 8'd3; dataIM = 8'd15;
      step();
      l = 1'b0; br = 1'b0;
      check("ld_over_br", pcc, 15);
      en = 1'b0; l = 1'b1; dataIM = 8'd3;
      step();
      l = 1'b0;
      check("stall_pcc", pcc, 15);
      en = 1'b1;

      // branch range
      do_load(8'd10);
      do_br(8'hFB);
      check("br_neg", pcc, 5);
      do_load(8'd20);
      do_br(8'd4);
      check("br_to_last", pcc, 24);
      check("br_to_last_aerr", aerr, 0);
      do_load(8'd20);
      do_br(8'd5);
      check("br_over_pcc", pcc, 0);
      check("br_over_aerr", aerr, 1);
      en = 1'b0; clr_err = 1'b1;
      step();
      clr_err = 1'b0; en = 1'b1;
      check("stall_clr_aerr", aerr, 0);
      check("stall_clr_pcc", pcc, 0);
      do_load(8'd2);
      do_br(8'hFD);
      check("br_under_pcc", pcc, 0);
      check("br_under_aerr", aerr, 1);
      do_clr();
      check("clr_aerr", aerr, 0);
      do_load(8'd30);
      check("ld_bad_pcc", pcc, 0);
      check("ld_bad_aerr", aerr, 1);
      do_clr();

      // nested call / return
      do_load(8'd3);
      do_call(8'd10);
      check("call1_pcc", pcc, 10);
      check("call1_sp", sp, 1);
      step();
      step();
      do_call(8'd20);
      check("call2_pcc", pcc, 20);
      check("call2_sp", sp, 2);
      do_ret();
      check("ret2_pcc", pcc, 13);
      check("ret2_sp", sp, 1);
      do_ret();
      check("ret1_pcc", pcc, 4);
      check("ret1_sp", sp, 0);
      do_load(8'd24);
      do_call(8'd5);
      check("call_wrap_pcc", pcc, 5);
      do_ret();
      check("ret_wrap_pcc", pcc, 0);

      // overflow / underflow with a LIFO model of return addresses
      do_load(8'd1);
      exp_q.push_back(8'd2);  do_call(8'd2);
      exp_q.push_back(8'd3);  do_call(8'd6);
      exp_q.push_back(8'd7);  do_call(8'd9);
      exp_q.push_back(8'd10); do_call(8'd12);
      check("full_sp", sp, 4);
      check("full_ovf", ovf, 0);
      do_call(8'd20);
      check("ovf_pcc", pcc, 12);
      check("ovf_sp", sp, 4);
      check("ovf_flag", ovf, 1);
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_back();
         do_ret();
         check("lifo_pcc", pcc, exp_v);
      end
      check("empty_sp", sp, 0);
      do_ret();
      check("unf_pcc", pcc, 2);
      check("unf_sp", sp, 0);
      check("unf_flag", unf, 1);
      ret = 1'b1; clr_err = 1'b1;
      step();
      ret = 1'b0; clr_err = 1'b0;
      check("unf_set_wins", unf, 1);
      check("ovf_cleared", ovf, 0);
      ret = 1'b1; call = 1'b1; dataIM = 8'd9;
      step();
      ret = 1'b0; call = 1'b0;
      check("ret_over_call_pcc", pcc, 2);
      check("ret_over_call_sp", sp, 0);
      do_clr();
      check("clr_unf", unf, 0);
      check("clr_pcc", pcc, 3);
      do_call(8'd200);
      check("call_bad_pcc", pcc, 0);
      check("call_bad_sp", sp, 1);
      check("call_bad_aerr", aerr, 1);
      do_ret();
      check("call_bad_ret", pcc, 4);
      en = 1'b0;

      // WIDTH=12, LAST_ADDR=4095, DEPTH=1, RESET_ADDR=100
      rst_n = 1'b0;
      #1;
      check("p_rst_pcc", b_pcc, 100);
      check("p_rst_sp", b_sp, 0);
      step();
      rst_n = 1'b1;
      b_en = 1'b1;
      step();
      check("p_inc", b_pcc, 101);
      b_l = 1'b1; b_dataIM = 12'd4095;
      step();
      b_l = 1'b0;
      check("p_ld_last", b_pcc, 4095);
      check("p_ld_aerr", b_aerr, 0);
      step();
      check("p_wrap", b_pcc, 0);
      b_call = 1'b1; b_dataIM = 12'd50;
      step();
      check("p_call_pcc", b_pcc, 50);
      check("p_call_sp", b_sp, 1);
      b_dataIM = 12'd60;
      step();
      b_call = 1'b0;
      check("p_ovf_pcc", b_pcc, 50);
      check("p_ovf_flag", b_ovf, 1);
      b_ret = 1'b1;
      step();
      b_ret = 1'b0;
      check("p_ret_pcc", b_pcc, 1);
      check("p_ret_sp", b_sp, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
